// File: rtl/tt_sel_seq.sv
// tt_sel_seq: drives the mux controller's select counter (reset / increment / enable) to reach a requested address
module tt_sel_seq #(
  parameter int ADDR_W     = 10,
  parameter int PULSE_CYC  = 2,
  parameter int GAP_CYC    = 2,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic              req_force,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, ENA_OFF, RST, INC_HI, INC_LO, SETTLE, DONE} state_t;
  state_t            r_state, w_nxt;
  logic [31:0]       r_cnt, w_lim;
  logic [ADDR_W-1:0] r_addr, r_delta, w_delta, r_cur;
  logic              r_ena_req, r_force, w_last, w_acc;
  logic              r_sel_rst_n, r_inc, r_ena, r_done, r_busy, r_ready;

  assign w_acc          = req_valid & r_ready;
  assign req_ready      = r_ready;
  assign ctrl_sel_rst_n = r_sel_rst_n;
  assign ctrl_sel_inc   = r_inc;
  assign ctrl_ena       = r_ena;
  assign cur_addr       = r_cur;
  assign busy           = r_busy;
  assign done           = r_done;

  // next state and remaining increment count; every timed state ends when its cycle count expires
  always_comb begin
    w_lim   = r_state == RST ? 32'(RST_CYC) : r_state == INC_HI ? 32'(PULSE_CYC) :
              r_state == INC_LO ? 32'(GAP_CYC) : 32'(SETTLE_CYC);
    w_last  = r_cnt == w_lim - 32'd1;
    w_nxt   = r_state;
    w_delta = r_delta;
    case (r_state)
      IDLE:    if (w_acc) w_nxt = ENA_OFF;
      ENA_OFF: if (w_last) begin
                 if (!r_force && r_addr == r_cur) w_nxt = SETTLE;
                 else if (!r_force && r_addr > r_cur) begin
                   w_nxt   = INC_HI;
                   w_delta = r_addr - r_cur;
                 end else w_nxt = RST;
               end
      RST:     if (w_last) begin
                 w_delta = r_addr;
                 w_nxt   = r_addr == '0 ? SETTLE : INC_HI;
               end
      INC_HI:  if (w_last) w_nxt = INC_LO;
      INC_LO:  if (w_last) begin
                 w_delta = r_delta - ADDR_W'(1);
                 w_nxt   = w_delta == '0 ? SETTLE : INC_HI;
               end
      SETTLE:  if (w_last) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // state register with per-state cycle counter and remaining pulse count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_delta <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state || r_state == IDLE) ? '0 : r_cnt + 32'd1;
      r_delta <= w_delta;
    end

  // capture the request fields at acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr    <= '0;
      r_ena_req <= 1'b0;
      r_force   <= 1'b0;
    end else if (w_acc) begin
      r_addr    <= req_addr;
      r_ena_req <= req_ena;
      r_force   <= req_force;
    end

  // outputs registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sel_rst_n <= 1'b0;
      r_inc       <= 1'b0;
      r_ena       <= 1'b0;
      r_cur       <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_sel_rst_n <= w_nxt != RST;
      r_inc       <= w_nxt == INC_HI;
      r_ena       <= w_nxt == DONE ? r_ena_req : w_nxt == IDLE ? r_ena : 1'b0;
      r_cur       <= (w_nxt == RST && r_state != RST) ? '0 :
                     (w_nxt == INC_HI && r_state != INC_HI) ? r_cur + ADDR_W'(1) : r_cur;
      r_done      <= w_nxt == DONE;
      r_busy      <= w_nxt != IDLE;
      r_ready     <= w_nxt == IDLE;
    end
endmodule
